// File: rtl/pet_needs_engine_if.sv
// Button inputs and display-facing buses of the virtual-pet needs engine.
interface pet_needs_engine_if;
    logic        btn_feed;
    logic        btn_play;
    logic        btn_heal;
    logic        btn_sleep;
    logic        btn_next;
    logic [32:0] needs_values;
    logic [7:0]  screen_param;
    logic        update;

    modport master (
        output btn_feed, btn_play, btn_heal, btn_sleep, btn_next,
        input  needs_values, screen_param, update
    );

    modport slave (
        input  btn_feed, btn_play, btn_heal, btn_sleep, btn_next,
        output needs_values, screen_param, update
    );
endinterface

// File: rtl/pet_needs_engine.sv
// Virtual-pet state: four saturating needs, AWAKE/SLEEPING/DEAD FSM and page selector.
// Optional macro REVIVE_EN: btn_heal in DEAD revives the pet at half needs.
module pet_needs_engine #(
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned DECAY_PERIOD = 10,
    parameter int unsigned NEED_MAX     = 100,
    parameter int unsigned ACTION_STEP  = 20,
    parameter int unsigned SLEEP_GAIN   = 2
) (
    input logic clk,
    input logic rst,
    pet_needs_engine_if.slave bus
);
    typedef enum logic [2:0] {AWAKE = 3'd0, SLEEPING = 3'd1, DEAD = 3'd2} state_t;

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DEC_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [7:0] MAX8  = 8'(NEED_MAX);
    localparam logic [7:0] HALF8 = 8'(NEED_MAX / 2);
    localparam logic [8:0] STEP9 = 9'(ACTION_STEP);
    localparam logic [8:0] GAIN9 = 9'(SLEEP_GAIN);

    logic [PRE_W-1:0] pre_cnt;
    logic [DEC_W-1:0] dec_cnt;
    logic             tick, decay;
    state_t           state, state_nx;
    logic [7:0]       hunger, energy, fun, health;
    logic [7:0]       hunger_nx, energy_nx, fun_nx, health_nx;
    logic [2:0]       page, page_nx;
    logic [1:0]       mood;
    logic [7:0]       min_he, min_all;
    logic             any_zero;
    logic             act_heal, act_feed, act_play, act_sleep;
    logic [32:0]      prev_nv;
    logic [7:0]       prev_sp;
    logic             update_r;

    // 9-bit add then decrement, clamped to NEED_MAX: never wraps at either end.
    function automatic logic [7:0] sat_step(input logic [7:0] v, input logic add,
                                            input logic [8:0] amt, input logic sub);
        logic [8:0] s;
        s = {1'b0, v} + (add ? amt : 9'd0);
        if (sub && s != 9'd0) s = s - 9'd1;
        if (s > {1'b0, MAX8}) s = {1'b0, MAX8};
        return s[7:0];
    endfunction

    assign tick  = (pre_cnt == PRE_W'(TICK_DIV - 1));
    assign decay = tick && (dec_cnt == DEC_W'(DECAY_PERIOD - 1));

    always_comb begin
        min_he  = (hunger < energy) ? hunger : energy;
        min_all = (min_he < fun) ? min_he : fun;
        if (state == DEAD)        mood = 2'd3;
        else if (min_all >= 8'd50) mood = 2'd0;
        else if (min_all >= 8'd20) mood = 2'd1;
        else                       mood = 2'd2;
    end

    always_comb begin
        state_nx  = state;
        hunger_nx = hunger;
        energy_nx = energy;
        fun_nx    = fun;
        health_nx = health;
        page_nx   = page;
        any_zero  = (hunger == 8'd0) || (energy == 8'd0) || (fun == 8'd0);

        act_heal  = (state == AWAKE) && bus.btn_heal;
        act_feed  = (state == AWAKE) && bus.btn_feed && !bus.btn_heal;
        act_play  = (state == AWAKE) && bus.btn_play && !bus.btn_heal && !bus.btn_feed;
        act_sleep = (state == SLEEPING) ? bus.btn_sleep :
                    (state == AWAKE) && bus.btn_sleep && !bus.btn_heal
                                     && !bus.btn_feed && !bus.btn_play;

        if (bus.btn_next) page_nx = (page == 3'd4) ? 3'd0 : page + 3'd1;

        case (state)
            AWAKE, SLEEPING: begin
                hunger_nx = sat_step(hunger, act_feed, STEP9, decay);
                fun_nx    = sat_step(fun, act_play, STEP9, decay);
                health_nx = sat_step(health, act_heal, STEP9, decay && any_zero);
                if (state == SLEEPING) energy_nx = sat_step(energy, decay, GAIN9, 1'b0);
                else                   energy_nx = sat_step(energy, 1'b0, 9'd0, decay);

                if (health_nx == 8'd0)
                    state_nx = DEAD;
                else if (state == AWAKE && act_sleep)
                    state_nx = SLEEPING;
                else if (state == SLEEPING && (act_sleep || (decay && energy_nx == MAX8)))
                    state_nx = AWAKE;
            end
            DEAD: begin
`ifdef REVIVE_EN
                if (bus.btn_heal) begin
                    hunger_nx = HALF8;
                    energy_nx = HALF8;
                    fun_nx    = HALF8;
                    health_nx = HALF8;
                    page_nx   = 3'd0;
                    state_nx  = AWAKE;
                end
`endif
            end
            default: state_nx = AWAKE;
        endcase
    end

    assign bus.needs_values = {state != DEAD, health, fun, energy, hunger};
    assign bus.screen_param = {state, mood, page};
    assign bus.update       = update_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt  <= '0;
            dec_cnt  <= '0;
            state    <= AWAKE;
            hunger   <= MAX8;
            energy   <= MAX8;
            fun      <= MAX8;
            health   <= MAX8;
            page     <= '0;
            prev_nv  <= {1'b1, MAX8, MAX8, MAX8, MAX8};
            prev_sp  <= '0;
            update_r <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) dec_cnt <= decay ? '0 : dec_cnt + 1'b1;
            state   <= state_nx;
            hunger  <= hunger_nx;
            energy  <= energy_nx;
            fun     <= fun_nx;
            health  <= health_nx;
            page    <= page_nx;
            // Previous-value copies lag the outputs by one cycle so update marks any change.
            prev_nv  <= bus.needs_values;
            prev_sp  <= bus.screen_param;
            update_r <= (bus.needs_values != prev_nv) || (bus.screen_param != prev_sp);
        end
    end
endmodule

// File: tb/tb_pet_needs_engine.sv
// Directed self-checking bench for pet_needs_engine with TICK_DIV=4, DECAY_PERIOD=2.
module tb_pet_needs_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   edges  = 0;

    pet_needs_engine_if bus();

    pet_needs_engine #(.TICK_DIV(4), .DECAY_PERIOD(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic press(input logic h, input logic f, input logic p, input logic s, input logic n);
        bus.btn_heal = h; bus.btn_feed = f; bus.btn_play = p; bus.btn_sleep = s; bus.btn_next = n;
        step(1);
        bus.btn_heal = 0; bus.btn_feed = 0; bus.btn_play = 0; bus.btn_sleep = 0; bus.btn_next = 0;
    endtask

    task automatic do_reset;
        bus.btn_heal = 0; bus.btn_feed = 0; bus.btn_play = 0; bus.btn_sleep = 0; bus.btn_next = 0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        edges = 0;
    endtask

    task automatic test_reset;
        int pulses;
        do_reset();
        checks++; if (bus.needs_values !== 33'h1_6464_6464) begin errors++; $display("FAIL reset_nv got=%h exp=%h", bus.needs_values, 33'h1_6464_6464); end
        checks++; if (bus.screen_param !== 8'h00) begin errors++; $display("FAIL reset_sp got=%h exp=%h", bus.screen_param, 8'h00); end
        checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b exp=0", bus.update); end
        step(8);
        checks++; if (bus.needs_values !== 33'h1_6463_6363) begin errors++; $display("FAIL first_decay got=%h exp=%h", bus.needs_values, 33'h1_6463_6363); end
        checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL upd_latency got=%b exp=0", bus.update); end
        pulses = 0;
        repeat (7) begin step(1); if (bus.update === 1'b1) pulses++; end
        checks++; if (pulses != 1) begin errors++; $display("FAIL decay_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_death;
        do_reset();
        step(800);
        checks++; if (bus.needs_values !== 33'h1_6400_0000) begin errors++; $display("FAIL starve got=%h exp=%h", bus.needs_values, 33'h1_6400_0000); end
        step(8);
        checks++; if (bus.needs_values !== 33'h1_6300_0000) begin errors++; $display("FAIL health_dec got=%h exp=%h", bus.needs_values, 33'h1_6300_0000); end
        step(792);
        checks++; if (bus.needs_values !== 33'h0_0000_0000) begin errors++; $display("FAIL dead_nv got=%h exp=%h", bus.needs_values, 33'h0); end
        checks++; if (bus.screen_param !== 8'h58) begin errors++; $display("FAIL dead_sp got=%h exp=%h", bus.screen_param, 8'h58); end
        press(0, 1, 0, 0, 0);
        step(16);
        checks++; if (bus.needs_values !== 33'h0_0000_0000) begin errors++; $display("FAIL dead_feed got=%h exp=%h", bus.needs_values, 33'h0); end
        press(0, 0, 0, 0, 1);
        checks++; if (bus.screen_param !== 8'h59) begin errors++; $display("FAIL dead_next got=%h exp=%h", bus.screen_param, 8'h59); end
        press(1, 0, 0, 0, 0);
`ifdef REVIVE_EN
        checks++; if (bus.needs_values !== 33'h1_3232_3232) begin errors++; $display("FAIL revive_nv got=%h exp=%h", bus.needs_values, 33'h1_3232_3232); end
        checks++; if (bus.screen_param !== 8'h00) begin errors++; $display("FAIL revive_sp got=%h exp=%h", bus.screen_param, 8'h00); end
`else
        checks++; if (bus.needs_values !== 33'h0_0000_0000) begin errors++; $display("FAIL dead_heal got=%h exp=%h", bus.needs_values, 33'h0); end
        checks++; if (bus.screen_param !== 8'h59) begin errors++; $display("FAIL dead_heal_sp got=%h exp=%h", bus.screen_param, 8'h59); end
`endif
    endtask

    task automatic test_feed;
        do_reset();
        step(80);
        press(0, 1, 0, 0, 0);
        checks++; if (bus.needs_values !== 33'h1_645A_5A64) begin errors++; $display("FAIL feed_sat got=%h exp=%h", bus.needs_values, 33'h1_645A_5A64); end
        step(406);
        checks++; if (bus.needs_values !== 33'h1_6428_2832) begin errors++; $display("FAIL pre_coinc got=%h exp=%h", bus.needs_values, 33'h1_6428_2832); end
        press(0, 1, 0, 0, 0);
        checks++; if (bus.needs_values !== 33'h1_6427_2745) begin errors++; $display("FAIL feed_decay got=%h exp=%h", bus.needs_values, 33'h1_6427_2745); end
        checks++; if (bus.screen_param !== 8'h08) begin errors++; $display("FAIL mood1 got=%h exp=%h", bus.screen_param, 8'h08); end
    endtask

    task automatic test_priority;
        do_reset();
        step(1120);
        repeat (3) press(0, 1, 0, 0, 0);
        step(77);
        checks++; if (bus.needs_values !== 33'h1_3200_0032) begin errors++; $display("FAIL prio_setup got=%h exp=%h", bus.needs_values, 33'h1_3200_0032); end
        press(1, 1, 1, 1, 0);
        checks++; if (bus.needs_values !== 33'h1_4600_0032) begin errors++; $display("FAIL prio_heal got=%h exp=%h", bus.needs_values, 33'h1_4600_0032); end
        checks++; if (bus.screen_param !== 8'h10) begin errors++; $display("FAIL prio_sp got=%h exp=%h", bus.screen_param, 8'h10); end
    endtask

    task automatic test_sleep;
        do_reset();
        step(32);
        press(0, 0, 0, 1, 0);
        checks++; if (bus.screen_param !== 8'h20) begin errors++; $display("FAIL sleep_enter got=%h exp=%h", bus.screen_param, 8'h20); end
        press(0, 0, 1, 0, 0);
        checks++; if (bus.needs_values !== 33'h1_6460_6060) begin errors++; $display("FAIL sleep_play got=%h exp=%h", bus.needs_values, 33'h1_6460_6060); end
        step(6);
        checks++; if (bus.needs_values !== 33'h1_645F_625F) begin errors++; $display("FAIL sleep_gain got=%h exp=%h", bus.needs_values, 33'h1_645F_625F); end
        checks++; if (bus.screen_param !== 8'h20) begin errors++; $display("FAIL still_sleep got=%h exp=%h", bus.screen_param, 8'h20); end
        step(8);
        checks++; if (bus.needs_values !== 33'h1_645E_645E) begin errors++; $display("FAIL wake_nv got=%h exp=%h", bus.needs_values, 33'h1_645E_645E); end
        checks++; if (bus.screen_param !== 8'h00) begin errors++; $display("FAIL auto_wake got=%h exp=%h", bus.screen_param, 8'h00); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp_page [6];
        int pulses;
        exp_page = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        do_reset();
        pulses = 0;
        bus.btn_next = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (bus.update === 1'b1) pulses++;
            checks++; if (bus.screen_param[2:0] !== exp_page[i]) begin errors++; $display("FAIL page_%0d got=%0d exp=%0d", i, bus.screen_param[2:0], exp_page[i]); end
        end
        bus.btn_next = 1'b0;
        repeat (2) begin step(1); if (bus.update === 1'b1) pulses++; end
        checks++; if (pulses != 6) begin errors++; $display("FAIL page_pulses got=%0d exp=6", pulses); end
    endtask

    initial begin
        test_reset();
        test_death();
        test_feed();
        test_priority();
        test_sleep();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
